// File: rtl/burst_syn_gen.sv
// burst_syn_gen
//   Multi-channel burst synchronisation generator. A master frame counter
//   (cnt) runs from a programmable period; NCH channel pulses of a common
//   programmable width are placed at per-channel offsets inside each frame.
//   Supports continuous or single-shot framing, re-alignment to an external
//   sync edge, and config updates that take effect only at frame boundaries.
//
// Ports
//   clk_sys     system clock
//   reset       synchronous reset, active-high
//   enable      1 = generator may run, 0 = force IDLE
//   mode        0 = continuous, 1 = single-shot
//   sw_trig     strobe starting one frame in single-shot mode
//   ext_sync    external re-alignment input (synchronous to clk_sys)
//   cfg_period  frame length in cycles (0 = off)
//   cfg_width   pulse width in cycles, common to all channels
//   cfg_delay   per-channel offset, channel k = bits [k*CNT_W +: CNT_W]
//   cfg_load    strobe capturing cfg_* into the shadow registers
//   burst_syn   channel sync pulses (registered)
//   frame_start one-cycle pulse for cnt==0 of every frame (registered)
//   busy        1 while the generator is in RUN
//   frame_cnt   count of frame_start pulses, wrapping

module burst_syn_gen #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 32,
  parameter int PW_W   = 16,
  parameter int FCNT_W = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 sw_trig,
  input  logic                 ext_sync,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [PW_W-1:0]      cfg_width,
  input  logic [NCH*CNT_W-1:0] cfg_delay,
  input  logic                 cfg_load,
  output logic [NCH-1:0]       burst_syn,
  output logic                 frame_start,
  output logic                 busy,
  output logic [FCNT_W-1:0]    frame_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [FCNT_W-1:0] FCNT_ONE = 1;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;

  logic [CNT_W-1:0]       sh_period_reg, act_period_reg;
  logic [PW_W-1:0]        sh_width_reg, act_width_reg;
  logic [NCH*CNT_W-1:0]   sh_delay_reg, act_delay_reg;
  logic                   load_pend_reg;

  logic                   sync_d_reg;
  logic                   sync_rise;
  logic                   xfer;
  logic                   at_end;
  logic                   in_run;
  logic [NCH-1:0]         hit;

  logic [NCH-1:0]         burst_reg;
  logic                   frame_start_reg;
  logic [FCNT_W-1:0]      frame_cnt_reg;

  assign sync_rise = ext_sync & ~sync_d_reg;
  assign at_end    = (cnt_reg == act_period_reg - CNT_ONE);
  assign in_run    = (state_reg == ST_RUN);

  // Next-state / counter logic. xfer marks the frame boundaries at which
  // the shadow config may be promoted to the active config.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    xfer       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        xfer     = load_pend_reg;
        if (enable && (act_period_reg != '0) && (!mode || sw_trig))
          state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable || (act_period_reg == '0)) begin
          // A zero period can only arrive via a boundary transfer; treat
          // it as "off" rather than letting cnt run to its full range.
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (sync_rise) begin
          // Restart wins over a coincident wrap: one frame_start either way.
          cnt_next = '0;
          xfer     = load_pend_reg;
        end else if (at_end) begin
          cnt_next = '0;
          if (mode)
            state_next = ST_IDLE;
          else
            xfer = load_pend_reg;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      sync_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sync_d_reg <= ext_sync;
    end
  end

  // Shadow/active config. A cfg_load in the same cycle as a transfer keeps
  // the pending flag set so the newer values are not lost.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sh_period_reg  <= '0;
      sh_width_reg   <= '0;
      sh_delay_reg   <= '0;
      act_period_reg <= '0;
      act_width_reg  <= '0;
      act_delay_reg  <= '0;
      load_pend_reg  <= 1'b0;
    end else begin
      if (cfg_load) begin
        sh_period_reg <= cfg_period;
        sh_width_reg  <= cfg_width;
        sh_delay_reg  <= cfg_delay;
      end
      if (cfg_load)
        load_pend_reg <= 1'b1;
      else if (xfer)
        load_pend_reg <= 1'b0;
      if (xfer) begin
        act_period_reg <= sh_period_reg;
        act_width_reg  <= sh_width_reg;
        act_delay_reg  <= sh_delay_reg;
      end
    end
  end

  // Per-channel window test. The end of the window is formed one bit wider
  // than cnt so delay+width never wraps back into the frame; since cnt never
  // reaches the period, pulses clip naturally at the frame end.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CNT_W-1:0] dly;
      logic [CNT_W:0]   dly_end;
      assign dly     = act_delay_reg[gi*CNT_W +: CNT_W];
      assign dly_end = {1'b0, dly} + {{(CNT_W + 1 - PW_W){1'b0}}, act_width_reg};
      assign hit[gi] = (act_width_reg != '0) && (cnt_reg >= dly) &&
                       ({1'b0, cnt_reg} < dly_end);
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      burst_reg       <= '0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      burst_reg       <= in_run ? hit : '0;
      frame_start_reg <= in_run && (cnt_reg == '0);
      if (in_run && (cnt_reg == '0))
        frame_cnt_reg <= frame_cnt_reg + FCNT_ONE;
    end
  end

  assign burst_syn   = burst_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign busy        = in_run;

endmodule
